dbg_trace: RTL and testbench

Parametrised successor to the pipeline debug mux, and it sits at the same point in the chip. Each probe bit is still mirrored to the logic analyzer and can be overridden from it. New in this block: a trigger-driven trace buffer that captures the post-override probe vector into a DEPTH-deep circular memory. Firmware arms the buffer, waits for a masked value match, and reads back pre- and post-trigger history.

---
 rtl/dbg_trace_pkg.sv | 16 +
 rtl/dbg_trace_if.sv | 39 +++
 rtl/dbg_trace_ram.sv | 31 +++
 rtl/dbg_trace.sv | 120 ++++++++++++
 tb/tb_dbg_trace.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the debug trace block: FSM state encoding and the
// default widths/depth used by the debug top level and firmware headers.
package dbg_pkg;

  localparam int PROBE_BW_DEF = 119;
  localparam int LA_BW_DEF    = 128;
  localparam int DEPTH_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dbg_trace_if.sv
// Logic-analyzer / firmware side of the debug trace block: override bus,
// trigger configuration and trace readback. The master is the analyzer or
// firmware, the slave is dbg_trace.
interface dbg_trace_if
  import dbg_pkg::*;
#(
  parameter int PROBE_BW = PROBE_BW_DEF,
  parameter int LA_BW    = LA_BW_DEF,
  parameter int DEPTH    = DEPTH_DEF
) ();

  localparam int AW = $clog2(DEPTH);

  logic [LA_BW-1:0]    la_data_in_i;
  logic [LA_BW-1:0]    la_oenb_i;
  logic [LA_BW-1:0]    la_data_out_o;
  logic                cfg_arm_i;
  logic [PROBE_BW-1:0] cfg_trig_mask_i;
  logic [PROBE_BW-1:0] cfg_trig_value_i;
  logic [AW-1:0]       cfg_post_i;
  logic [AW-1:0]       rd_addr_i;
  logic [PROBE_BW-1:0] rd_data_o;
  logic [1:0]          state_o;
  logic [AW-1:0]       trig_ptr_o;
  logic                wrapped_o;

  modport master (
    output la_data_in_i, la_oenb_i, cfg_arm_i, cfg_trig_mask_i,
           cfg_trig_value_i, cfg_post_i, rd_addr_i,
    input  la_data_out_o, rd_data_o, state_o, trig_ptr_o, wrapped_o
  );

  modport slave (
    input  la_data_in_i, la_oenb_i, cfg_arm_i, cfg_trig_mask_i,
           cfg_trig_value_i, cfg_post_i, rd_addr_i,
    output la_data_out_o, rd_data_o, state_o, trig_ptr_o, wrapped_o
  );

endinterface

// File: rtl/dbg_trace_ram.sv
// Trace storage: DEPTH x W, one synchronous write port and one synchronous
// read port with read-old-data behaviour. Kept separate so it can be
// replaced by an SRAM macro.
module dbg_trace_ram #(
  parameter int W     = 119,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem [DEPTH];

  // Storage array is not reset so it maps cleanly onto a macro.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Registered read; a same-cycle write to this address returns old data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rd_data_o <= '0;
    else          rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/dbg_trace.sv
// Pipeline debug mux with trigger-driven trace buffer. Probes are mirrored
// to the logic analyzer and can be overridden from it; the post-override
// vector is captured into a circular buffer around a masked-match trigger.
module dbg_trace
  import dbg_pkg::*;
#(
  parameter int PROBE_BW = PROBE_BW_DEF,
  parameter int LA_BW    = LA_BW_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PROBE_BW-1:0] probe_i,
  output logic [PROBE_BW-1:0] probe_o,
  dbg_trace_if.slave          dbg
);

  localparam int AW = $clog2(DEPTH);

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       cnt_q;
  logic [AW-1:0]       trig_ptr_q;
  logic                wrapped_q;
  logic [PROBE_BW-1:0] mask_q;
  logic [PROBE_BW-1:0] value_q;
  logic                hit;
  logic                we;

  // Override bits with an active-low enable; injected values are traced too.
  assign probe_o = (probe_i & dbg.la_oenb_i[PROBE_BW-1:0]) |
                   (dbg.la_data_in_i[PROBE_BW-1:0] & ~dbg.la_oenb_i[PROBE_BW-1:0]);
  assign dbg.la_data_out_o = LA_BW'(probe_i);

  assign hit = ((probe_o ^ value_q) & mask_q) == '0;

  generate
    if (LA_BW > PROBE_BW) begin : g_la_upper
      logic unused_la_upper;
      assign unused_la_upper = ^{dbg.la_data_in_i[LA_BW-1:PROBE_BW],
                                 dbg.la_oenb_i[LA_BW-1:PROBE_BW]};
    end
  endgenerate

  // Next-state and write enable; an arm pulse restarts capture from any state.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    if (dbg.cfg_arm_i) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          we = 1'b1;
          if (hit) state_d = (cnt_q == '0) ? DONE : POST;
        end
        POST: begin
          we = 1'b1;
          if (cnt_q <= AW'(1)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Trigger configuration is captured on arm so firmware may change it freely.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q  <= '0;
      value_q <= '0;
    end else if (dbg.cfg_arm_i) begin
      mask_q  <= dbg.cfg_trig_mask_i;
      value_q <= dbg.cfg_trig_value_i;
    end
  end

  // Write pointer, wrap flag, post-trigger countdown and trigger address.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
    end else if (dbg.cfg_arm_i) begin
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      cnt_q     <= dbg.cfg_post_i;
    end else if (we) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_ptr_q == AW'(DEPTH - 1)) wrapped_q <= 1'b1;
      if (state_q == POST) cnt_q <= cnt_q - 1'b1;
      if (state_q == ARMED && hit) trig_ptr_q <= wr_ptr_q;
    end
  end

  dbg_trace_ram #(
    .W     (PROBE_BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .we_i      (we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (probe_o),
    .rd_addr_i (dbg.rd_addr_i),
    .rd_data_o (dbg.rd_data_o)
  );

  assign dbg.state_o    = state_q;
  assign dbg.trig_ptr_o = trig_ptr_q;
  assign dbg.wrapped_o  = wrapped_q;

endmodule

// File: tb/tb_dbg_trace.sv
// Scoreboard bench for dbg_trace: stimulus pushes hand-computed expectations
// tagged with the cycle they become visible; a negedge monitor pops them.
module tb_dbg_trace;
  import dbg_pkg::*;

  localparam int PBW   = 119;
  localparam int LBW   = 128;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam int S_PROBE = 0;
  localparam int S_LAOUT = 1;
  localparam int S_STATE = 2;
  localparam int S_TRIG  = 3;
  localparam int S_WRAP  = 4;
  localparam int S_RD    = 5;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [PBW-1:0] probe_i;
  logic [PBW-1:0] probe_o;
  int             cyc = 0;

  dbg_trace_if #(.PROBE_BW(PBW), .LA_BW(LBW), .DEPTH(DEPTH)) dbg ();

  dbg_trace #(.PROBE_BW(PBW), .LA_BW(LBW), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .probe_i (probe_i),
    .probe_o (probe_o),
    .dbg     (dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    int           sel;
    logic [127:0] exp;
    string        name;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [127:0] sample(input int sel);
    case (sel)
      S_PROBE: return 128'(probe_o);
      S_LAOUT: return dbg.la_data_out_o;
      S_STATE: return 128'(dbg.state_o);
      S_TRIG:  return 128'(dbg.trig_ptr_o);
      S_WRAP:  return 128'(dbg.wrapped_o);
      default: return 128'(dbg.rd_data_o);
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle, away from posedge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [127:0] act;
        act = sample(sb[i].sel);
        checks++;
        if (act === sb[i].exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", sb[i].name, act, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic checkOutput(input string name, input int sel, input logic [127:0] exp, input int lat);
    chk_t c;
    c.due  = cyc + lat;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic checkOutputNow(input string name, input int sel, input logic [127:0] exp);
    logic [127:0] act;
    act = sample(sel);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic readExpect(input string name, input int addr, input logic [127:0] exp);
    dbg.rd_addr_i = AW'(addr);
    checkOutput(name, S_RD, exp, 1);
  endtask

  task automatic applyStimulus(input logic [PBW-1:0] p);
    @(posedge clk);
    #1;
    dbg.cfg_arm_i = 1'b0;
    probe_i       = p;
  endtask

  task automatic armTrace(input logic [PBW-1:0] mask, input logic [PBW-1:0] value, input int post);
    dbg.cfg_arm_i        = 1'b1;
    dbg.cfg_trig_mask_i  = mask;
    dbg.cfg_trig_value_i = value;
    dbg.cfg_post_i       = AW'(post);
  endtask

  typedef struct {
    logic [PBW-1:0] p;
    logic [LBW-1:0] oenb;
    logic [LBW-1:0] din;
    logic [PBW-1:0] expo;
    logic [LBW-1:0] expla;
  } ov_t;

  ov_t ov[4];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    probe_i              = '0;
    dbg.la_data_in_i     = '0;
    dbg.la_oenb_i        = '1;
    dbg.cfg_arm_i        = 1'b0;
    dbg.cfg_trig_mask_i  = '0;
    dbg.cfg_trig_value_i = '0;
    dbg.cfg_post_i       = '0;
    dbg.rd_addr_i        = '0;

    ov[0] = '{p: '0, oenb: ~(128'h1 << 5), din: 128'h20, expo: 119'h20, expla: '0};
    ov[1] = '{p: 119'h1_2345_6789, oenb: '1, din: '1, expo: 119'h1_2345_6789,
              expla: 128'h1_2345_6789};
    ov[2] = '{p: 119'h12_3400, oenb: ~128'hFF, din: '1, expo: 119'h12_34FF,
              expla: 128'h12_3400};
    ov[3] = '{p: (119'h1 << 118) | 119'h1, oenb: ~(128'h1 << 118), din: '0,
              expo: 119'h1, expla: (128'h1 << 118) | 128'h1};

    // reset values
    applyStimulus('0);
    checkOutput("rst_state", S_STATE, 0, 0);
    checkOutput("rst_trig", S_TRIG, 0, 0);
    checkOutput("rst_wrap", S_WRAP, 0, 0);
    checkOutput("rst_rd", S_RD, 0, 0);
    applyStimulus('0);
    rst_n = 1'b1;

    // override mux and analyzer mirror
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ov[i].p);
      dbg.la_oenb_i    = ov[i].oenb;
      dbg.la_data_in_i = ov[i].din;
      checkOutput($sformatf("ov%0d_probe", i), S_PROBE, 128'(ov[i].expo), 0);
      checkOutput($sformatf("ov%0d_la", i), S_LAOUT, ov[i].expla, 0);
      #1;
      checkOutputNow($sformatf("ov%0d_probe_now", i), S_PROBE, 128'(ov[i].expo));
      checkOutputNow($sformatf("ov%0d_la_now", i), S_LAOUT, ov[i].expla);
    end
    applyStimulus('0);
    dbg.la_oenb_i    = '1;
    dbg.la_data_in_i = '0;

    // trigger on 0x40 with 4 post samples
    applyStimulus('0);
    armTrace(119'hFF, 119'h40, 4);
    for (int k = 1; k <= 64; k++) applyStimulus(PBW'(k));
    checkOutput("t1_hit_armed", S_STATE, 1, 0);
    for (int k = 65; k <= 68; k++) begin
      applyStimulus(PBW'(k));
      checkOutput("t1_post", S_STATE, 2, 0);
      if (k == 65) checkOutput("t1_trig", S_TRIG, 15, 0);
    end
    applyStimulus(PBW'(69));
    checkOutput("t1_done", S_STATE, 3, 0);
    checkOutput("t1_wrap", S_WRAP, 1, 0);
    applyStimulus(PBW'(70)); readExpect("t1_rd15", 15, 128'h40);
    applyStimulus(PBW'(71)); readExpect("t1_rd0", 0, 128'h41);
    applyStimulus(PBW'(72)); readExpect("t1_rd1", 1, 128'h42);
    applyStimulus(PBW'(73)); readExpect("t1_rd2", 2, 128'h43);
    applyStimulus(PBW'(74)); readExpect("t1_rd3", 3, 128'h44);
    applyStimulus(PBW'(75)); readExpect("t1_rd4", 4, 128'h35);
    applyStimulus(PBW'(76)); readExpect("t1_rd14", 14, 128'h3F);
    checkOutput("t1_still_done", S_STATE, 3, 0);

    // mask of zero: immediate trigger, no post samples
    applyStimulus(PBW'(8'h77));
    armTrace('0, 119'h5A, 0);
    applyStimulus(PBW'(8'hAB));
    checkOutput("t2_armed", S_STATE, 1, 0);
    applyStimulus(PBW'(8'hCD));
    checkOutput("t2_done", S_STATE, 3, 0);
    checkOutput("t2_trig", S_TRIG, 0, 0);
    checkOutput("t2_wrap", S_WRAP, 0, 0);
    readExpect("t2_rd0", 0, 128'hAB);
    applyStimulus(PBW'(8'hCE));
    readExpect("t2_rd1_frozen", 1, 128'h42);

    // wrap: hit 20 samples after arming, 3 post samples
    applyStimulus(PBW'(8'hFF));
    armTrace(119'hFF, 119'h94, 3);
    for (int j = 0; j < 24; j++) begin
      applyStimulus(PBW'(8'h80 + j));
      if (j == 5)  checkOutput("t3_nowrap", S_WRAP, 0, 0);
      if (j == 17) checkOutput("t3_wrapped", S_WRAP, 1, 0);
      if (j == 20) checkOutput("t3_hit_armed", S_STATE, 1, 0);
      if (j == 21) checkOutput("t3_post", S_STATE, 2, 0);
      if (j == 21) checkOutput("t3_trig", S_TRIG, 4, 0);
    end
    applyStimulus(PBW'(8'h98));
    checkOutput("t3_done", S_STATE, 3, 0);
    checkOutput("t3_wrap_done", S_WRAP, 1, 0);
    applyStimulus(PBW'(8'h99)); readExpect("t3_oldest", 8, 128'h88);
    applyStimulus(PBW'(8'h9A)); readExpect("t3_newest", 7, 128'h97);
    applyStimulus(PBW'(8'h9B)); readExpect("t3_hit", 4, 128'h94);
    applyStimulus(PBW'(8'h9C)); readExpect("t3_prehit", 3, 128'h93);
    applyStimulus(PBW'(8'h9D)); readExpect("t3_rd15", 15, 128'h8F);

    // re-arm during POST, then reset during POST
    applyStimulus('0);
    armTrace(119'hFF, 119'h10, 10);
    applyStimulus(PBW'(8'h10));
    applyStimulus(PBW'(8'h11));
    checkOutput("t4_post", S_STATE, 2, 0);
    applyStimulus(PBW'(8'h12));
    armTrace(119'hFF, 119'h55, 5);
    applyStimulus(PBW'(8'h33));
    checkOutput("t4_rearmed", S_STATE, 1, 0);
    checkOutput("t4_rearm_wrap", S_WRAP, 0, 0);
    applyStimulus(PBW'(8'h55));
    applyStimulus(PBW'(8'h56));
    checkOutput("t4_post2", S_STATE, 2, 0);
    checkOutput("t4_trig", S_TRIG, 1, 0);
    applyStimulus(PBW'(8'h57));
    rst_n = 1'b0;
    checkOutput("t4_rst_state", S_STATE, 0, 0);
    checkOutput("t4_rst_trig", S_TRIG, 0, 0);
    checkOutput("t4_rst_rd", S_RD, 0, 0);
    applyStimulus(PBW'(8'h99));
    applyStimulus(PBW'(8'h9A));
    rst_n = 1'b1;
    applyStimulus(PBW'(8'h9B));
    checkOutput("t4_idle", S_STATE, 0, 0);
    readExpect("t4_rd0", 0, 128'h33);
    applyStimulus(PBW'(8'h9C)); readExpect("t4_rd1", 1, 128'h55);
    applyStimulus(PBW'(8'h9D)); readExpect("t4_rd2", 2, 128'h56);
    applyStimulus(PBW'(8'h9E)); readExpect("t4_rd3", 3, 128'h93);

    // fill all entries with known data, then sweep the read port
    applyStimulus('0);
    armTrace('0, '0, 15);
    for (int j = 0; j < 16; j++) applyStimulus(PBW'(8'hA0 + j));
    applyStimulus(PBW'(8'hB0));
    checkOutput("t5_done", S_STATE, 3, 0);
    checkOutput("t5_wrap", S_WRAP, 1, 0);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(PBW'(8'hB1 + a));
      readExpect($sformatf("t5_rd%0d", a), a, 128'(8'hA0 + a));
    end

    // read-during-write returns the old contents
    applyStimulus('0);
    armTrace(119'hFF, 119'hFF, 0);
    applyStimulus(PBW'(8'hC0)); readExpect("t6_rdw0", 0, 128'hA0);
    applyStimulus(PBW'(8'hC1)); readExpect("t6_after0", 0, 128'hC0);
    applyStimulus(PBW'(8'hC2)); readExpect("t6_rdw2", 2, 128'hA2);
    applyStimulus(PBW'(8'hC3)); readExpect("t6_after2", 2, 128'hC2);

    for (int i = 0; i < 3; i++) applyStimulus('0);
    while (sb.size() > 0) begin
      checks++;
      $display("[TB] FAIL %s: got no sample expected 0x%0h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
